// File: rtl/pixel_stream_transmitter.sv
// Paced raster pixel transmitter: derives a pixel clock from I_CLK, walks
// active / horizontal-blank / vertical-blank slots, and emits one buffered
// upstream pixel per active slot through a 2-entry elastic buffer.
module pixel_stream_transmitter #(
  parameter int P_FRAME_COLUMNS     = 640,
  parameter int P_FRAME_ROWS        = 480,
  parameter int P_PIXEL_DEPTH       = 24,
  parameter int P_H_BLANK           = 160,
  parameter int P_V_BLANK           = 45,
  parameter int P_PIXEL_CLK_HALF    = 7,
  parameter int P_FRAME_COLUMN_BITS = $clog2(P_FRAME_COLUMNS),
  parameter int P_FRAME_ROW_BITS    = $clog2(P_FRAME_ROWS)
) (
  input  logic                           I_CLK,
  input  logic                           I_RESET,
  input  logic                           I_ENABLE,
  input  logic [P_PIXEL_DEPTH-1:0]       I_PIXEL,
  input  logic                           I_PIXEL_VALID,
  output logic                           O_PIXEL_READY,
  output logic                           O_PIXEL_CLK,
  output logic                           O_DATA_VALID,
  output logic [P_PIXEL_DEPTH-1:0]       O_PIXEL,
  output logic [P_FRAME_COLUMN_BITS-1:0] O_PIXEL_COLUMN,
  output logic [P_FRAME_ROW_BITS-1:0]    O_PIXEL_ROW,
  output logic                           O_FRAME_START,
  output logic                           O_UNDERFLOW
);

  localparam int LP_H_TOTAL = P_FRAME_COLUMNS + P_H_BLANK;
  localparam int LP_V_TOTAL = P_FRAME_ROWS + P_V_BLANK;
  localparam int LP_HC_W    = (LP_H_TOTAL > 1) ? $clog2(LP_H_TOTAL) : 1;
  localparam int LP_VC_W    = (LP_V_TOTAL > 1) ? $clog2(LP_V_TOTAL) : 1;
  localparam int LP_DIV_W   = (P_PIXEL_CLK_HALF > 1) ? $clog2(P_PIXEL_CLK_HALF) : 1;

  localparam logic [LP_DIV_W-1:0] LP_DIV_MAX   = LP_DIV_W'(P_PIXEL_CLK_HALF - 1);
  localparam logic [LP_HC_W-1:0]  LP_H_LAST    = LP_HC_W'(LP_H_TOTAL - 1);
  localparam logic [LP_VC_W-1:0]  LP_V_LAST    = LP_VC_W'(LP_V_TOTAL - 1);
  localparam logic [LP_HC_W-1:0]  LP_H_ACTIVE  = LP_HC_W'(P_FRAME_COLUMNS);
  localparam logic [LP_VC_W-1:0]  LP_V_ACTIVE  = LP_VC_W'(P_FRAME_ROWS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_HBLANK,
    S_VBLANK
  } state_t;

  // Region of a slot, purely from its raster coordinates.
  function automatic state_t slot_state(input logic [LP_HC_W-1:0] h,
                                        input logic [LP_VC_W-1:0] v);
    if (v >= LP_V_ACTIVE) return S_VBLANK;
    if (h >= LP_H_ACTIVE) return S_HBLANK;
    return S_ACTIVE;
  endfunction

  // ---------------------------------------------------------------------------
  // Pixel clock divider
  // ---------------------------------------------------------------------------
  logic [LP_DIV_W-1:0] r_div;
  logic                r_pix_clk;
  logic                w_update;

  // Falling edge of the pixel clock is where every stream output advances.
  assign w_update = (r_div == LP_DIV_MAX) && r_pix_clk;

  // Free-running half-period counter; toggles the pixel clock on terminal count.
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values of its neighbours, regardless of statement order.
  always_ff @(posedge I_CLK or negedge I_RESET) begin
    if (!I_RESET) begin
      r_div     <= '0;
      r_pix_clk <= 1'b1;
    end else if (r_div == LP_DIV_MAX) begin
      r_div     <= '0;
      r_pix_clk <= ~r_pix_clk;
    end else begin
      r_div     <= r_div + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Two-entry elastic buffer
  // ---------------------------------------------------------------------------
  logic [P_PIXEL_DEPTH-1:0] r_mem [2];
  logic                     r_wr_ptr;
  logic                     r_rd_ptr;
  logic [1:0]               r_count;
  logic                     w_full;
  logic                     w_empty;
  logic                     w_push;
  logic                     w_pop;
  logic [P_PIXEL_DEPTH-1:0] w_head;

  assign w_full        = (r_count == 2'd2);
  assign w_empty       = (r_count == 2'd0);
  assign O_PIXEL_READY = !w_full;
  assign w_push        = I_PIXEL_VALID && !w_full;
  assign w_head        = r_mem[r_rd_ptr];

  // Storage write; entries are only read after being written, so no reset.
  // NOTE: the data array is deliberately left out of reset -- occupancy is
  // tracked by r_count, and resetting storage would only add reset fan-out.
  always_ff @(posedge I_CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= I_PIXEL;
  end

  // Pointer and occupancy bookkeeping for simultaneous push/pop.
  always_ff @(posedge I_CLK or negedge I_RESET) begin
    if (!I_RESET) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Raster state machine
  // ---------------------------------------------------------------------------
  state_t             r_state;
  state_t             w_state_next;
  logic [LP_HC_W-1:0] r_hcount;
  logic [LP_HC_W-1:0] w_h_next;
  logic [LP_VC_W-1:0] r_vcount;
  logic [LP_VC_W-1:0] w_v_next;
  logic               w_frame_start;

  // State and slot-counter registers.
  always_ff @(posedge I_CLK or negedge I_RESET) begin
    if (!I_RESET) begin
      r_state  <= S_IDLE;
      r_hcount <= '0;
      r_vcount <= '0;
    end else begin
      r_state  <= w_state_next;
      r_hcount <= w_h_next;
      r_vcount <= w_v_next;
    end
  end

  // Next slot: advance the raster on update edges, frame boundary samples enable.
  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_next  = r_state;
    w_h_next      = r_hcount;
    w_v_next      = r_vcount;
    w_frame_start = 1'b0;
    if (w_update) begin
      if (r_state == S_IDLE) begin
        if (I_ENABLE) begin
          w_state_next  = S_ACTIVE;
          w_h_next      = '0;
          w_v_next      = '0;
          w_frame_start = 1'b1;
        end
      end else if (r_hcount != LP_H_LAST) begin
        w_h_next     = r_hcount + 1'b1;
        w_state_next = slot_state(w_h_next, r_vcount);
      end else if (r_vcount != LP_V_LAST) begin
        w_h_next     = '0;
        w_v_next     = r_vcount + 1'b1;
        w_state_next = slot_state('0, w_v_next);
      end else begin
        w_h_next = '0;
        w_v_next = '0;
        if (I_ENABLE) begin
          w_state_next  = S_ACTIVE;
          w_frame_start = 1'b1;
        end else begin
          w_state_next  = S_IDLE;
        end
      end
    end
  end

  // An active slot consumes the buffer head if there is one; an empty buffer
  // skips the slot rather than stalling the raster.
  assign w_pop = w_update && (w_state_next == S_ACTIVE) && !w_empty;

  // ---------------------------------------------------------------------------
  // Registered stream outputs
  // ---------------------------------------------------------------------------
  logic                           r_data_valid;
  logic [P_PIXEL_DEPTH-1:0]       r_pixel;
  logic [P_FRAME_COLUMN_BITS-1:0] r_column;
  logic [P_FRAME_ROW_BITS-1:0]    r_row;
  logic                           r_frame_start;
  logic                           r_underflow;

  // Load the new slot's outputs on update edges; blanks hold column/row.
  always_ff @(posedge I_CLK or negedge I_RESET) begin
    if (!I_RESET) begin
      r_data_valid  <= 1'b0;
      r_pixel       <= '0;
      r_column      <= '0;
      r_row         <= '0;
      r_frame_start <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      r_frame_start <= w_frame_start;
      if (w_update) begin
        if (w_state_next == S_ACTIVE) begin
          r_column     <= w_h_next[P_FRAME_COLUMN_BITS-1:0];
          r_row        <= w_v_next[P_FRAME_ROW_BITS-1:0];
          r_data_valid <= !w_empty;
          r_pixel      <= w_empty ? '0 : w_head;
          if (w_empty) r_underflow <= 1'b1;
        end else begin
          r_data_valid <= 1'b0;
          r_pixel      <= '0;
        end
      end
    end
  end

  assign O_PIXEL_CLK    = r_pix_clk;
  assign O_DATA_VALID   = r_data_valid;
  assign O_PIXEL        = r_pixel;
  assign O_PIXEL_COLUMN = r_column;
  assign O_PIXEL_ROW    = r_row;
  assign O_FRAME_START  = r_frame_start;
  assign O_UNDERFLOW    = r_underflow;

endmodule

// File: doc/pixel_stream_transmitter.md
Name: pixel_stream_transmitter

Overview:
- Generates a paced raster pixel stream (pixel clock, data-valid, pixel) from a buffered upstream pixel source.
- Feeds the colorspace/matrix front end in simulation and loopback, and drives the output video path in silicon.
- Owns raster timing: active, horizontal-blank and vertical-blank regions, plus a derived pixel clock.

Parameters:
P_FRAME_COLUMNS, 640, active pixels per row
P_FRAME_ROWS, 480, active rows per frame
P_PIXEL_DEPTH, 24, bits per pixel (RGB, 8 per subpixel)
P_H_BLANK, 160, blank pixel slots after each row
P_V_BLANK, 45, blank rows after each frame
P_PIXEL_CLK_HALF, 7, I_CLK cycles per O_PIXEL_CLK half period (≥1)
P_FRAME_COLUMN_BITS, $clog2(P_FRAME_COLUMNS), column width
P_FRAME_ROW_BITS, $clog2(P_FRAME_ROWS), row width

Ports:
I_CLK  in  1  system clock
I_RESET  in  1  asynchronous, active-low reset
I_ENABLE  in  1  run request; sampled only at frame boundaries
I_PIXEL  in  P_PIXEL_DEPTH  upstream pixel
I_PIXEL_VALID  in  1  upstream pixel present
O_PIXEL_READY  out  1  buffer can accept; transfer when VALID&&READY
O_PIXEL_CLK  out  1  derived pixel clock
O_DATA_VALID  out  1  O_PIXEL carries an active pixel this slot
O_PIXEL  out  P_PIXEL_DEPTH  output pixel, 0 when not valid
O_PIXEL_COLUMN  out  P_FRAME_COLUMN_BITS  column of current active slot
O_PIXEL_ROW  out  P_FRAME_ROW_BITS  row of current active slot
O_FRAME_START  out  1  one-I_CLK pulse at update edge of slot (0,0)
O_UNDERFLOW  out  1  sticky: active slot found buffer empty

Behaviour:
- Reset (async assert, sync release): O_PIXEL_CLK=1; O_DATA_VALID=0; O_PIXEL=0; column=0; row=0; O_FRAME_START=0; O_UNDERFLOW=0; buffer empty; O_PIXEL_READY=1; state IDLE; divider=0.
- Divider: counter 0..P_PIXEL_CLK_HALF-1, runs in every state. Toggle O_PIXEL_CLK when counter hits max, then clear. Pixel period = 2*P_PIXEL_CLK_HALF I_CLK cycles.
- Update edge: the I_CLK edge where O_PIXEL_CLK goes 1→0. All stream outputs (O_DATA_VALID, O_PIXEL, column, row) change only at update edges. They are stable across the following rising edge of O_PIXEL_CLK.
- Buffer: 2-entry FIFO. O_PIXEL_READY = !full, registered-independent. Push on VALID&&READY. Pop once per active slot if non-empty. Push and pop in the same cycle are both allowed; with full, pop frees space the next cycle only.
- States: IDLE, ACTIVE, HBLANK, VBLANK. Slot counters: hcount over P_FRAME_COLUMNS+P_H_BLANK, vcount over P_FRAME_ROWS+P_V_BLANK.
- IDLE: outputs invalid. At an update edge with I_ENABLE=1 → ACTIVE at slot (0,0) and pulse O_FRAME_START.
- ACTIVE: hcount<COLUMNS and vcount<ROWS. If buffer non-empty: pop, O_PIXEL=head, O_DATA_VALID=1. If empty: O_PIXEL=0, O_DATA_VALID=0, set O_UNDERFLOW, and the slot is skipped (the raster does not stall). Column=hcount, row=vcount.
- HBLANK: hcount≥COLUMNS. Invalid, O_PIXEL=0, column/row hold their last active values. Wrap of hcount increments vcount.
- VBLANK: vcount≥ROWS; invalid. At frame wrap (last slot of VBLANK): if I_ENABLE=1 → next frame (0,0) with O_FRAME_START; else → IDLE.
- Deasserting I_ENABLE mid-frame has no effect until the frame wrap.
- O_UNDERFLOW clears only on reset.

Test Plan:
Use COLUMNS=4, ROWS=2, H_BLANK=2, V_BLANK=1, HALF=2; 6×3=18 slots/frame, 4 I_CLK per slot.
- Reset mid-frame: assert reset → all outputs at reset values that same cycle (async); release → O_PIXEL_CLK first falls after 2 cycles, IDLE.
- Full frame: enable=1, upstream always valid with incrementing pixels 1..8 → valids at (0,0)=1…(3,0)=4, (0,1)=5…(3,1)=8. Two invalid HBLANK slots per row, one 6-slot VBLANK row, O_FRAME_START once per frame, O_UNDERFLOW=0.
- Backpressure: upstream valid held; READY drops after two pushes and reasserts one cycle after each pop. No pixel lost or duplicated across 2 frames.
- Underflow: withhold pixel 3 → slot (2,0) has DATA_VALID=0 and O_PIXEL=0, O_UNDERFLOW=1 sticky; slot (3,0) carries pixel 3.
- Enable drop: deassert I_ENABLE during row 0 → frame completes (all 8 pixels), then IDLE with no O_FRAME_START. Reassert → restart at (0,0).
- Stability check: O_PIXEL/O_DATA_VALID never change on an O_PIXEL_CLK rising edge (checked by assertion throughout all tests).
